// File: rtl/everloop_pkg.sv
// Shared types and default 50 MHz timing for the Everloop one-wire LED driver.
package everloop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_SHIFT,
    ST_LATCH
  } evl_state_e;

  localparam int EVL_T_BIT      = 63;
  localparam int EVL_T0H        = 20;
  localparam int EVL_T1H        = 40;
  localparam int EVL_T_LATCH    = 2500;

  localparam int EVL_BYTES_GRB  = 3;
  localparam int EVL_BYTES_GRBW = 4;

  // Upper byte of byte*(bri+1): bri=255 is the identity, bri=0 gives zero.
  function automatic logic [7:0] evl_scale(input logic [7:0] b, input logic [7:0] bri);
    return 8'((16'(b) * (16'(bri) + 16'd1)) >> 8);
  endfunction

endpackage

// File: rtl/everloop_bit_enc.sv
// One-wire bit encoder: times one bit period and drives the high/low pulse.
module everloop_bit_enc #(
  parameter int T_BIT = 63,
  parameter int T0H   = 20,
  parameter int T1H   = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_val,
  input  logic bit_start,
  output logic led_ctl,
  output logic bit_last
);

  localparam int CW = (T_BIT > 1) ? $clog2(T_BIT) : 1;
  localparam int HW = CW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(T_BIT - 1);
  localparam logic [HW-1:0] HI0      = HW'(T0H);
  localparam logic [HW-1:0] HI1      = HW'(T1H);

  logic [CW-1:0] cnt_q;
  logic [HW-1:0] cnt_inc;
  logic          val_q;
  logic          active_q;
  logic          led_q;

  assign cnt_inc  = {1'b0, cnt_q} + 1'b1;
  assign bit_last = active_q && (cnt_q == CNT_LAST);
  assign led_ctl  = led_q;

  // A new bit_start in the last clock of a bit chains bits with no gap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q    <= '0;
      val_q    <= 1'b0;
      active_q <= 1'b0;
      led_q    <= 1'b0;
    end else if (bit_start) begin
      cnt_q    <= '0;
      val_q    <= bit_val;
      active_q <= 1'b1;
      led_q    <= 1'b1;
    end else if (active_q) begin
      if (bit_last) begin
        cnt_q    <= '0;
        active_q <= 1'b0;
        led_q    <= 1'b0;
      end else begin
        cnt_q <= cnt_inc[CW-1:0];
        led_q <= cnt_inc < (val_q ? HI1 : HI0);
      end
    end
  end

endmodule

// File: rtl/everloop_stream.sv
// Everloop LED-ring streamer: fetches frame bytes from RAM and serialises them MSB-first.
// Optional global brightness scaling is enabled by defining EVERLOOP_BRIGHTNESS_EN.
module everloop_stream
  import everloop_pkg::*;
#(
  parameter int N_LEDS        = 35,
  parameter int BYTES_PER_LED = EVL_BYTES_GRB,
  parameter int ADR_WIDTH     = 11,
  parameter int BASE_ADR      = 0,
  parameter int T_BIT         = EVL_T_BIT,
  parameter int T0H           = EVL_T0H,
  parameter int T1H           = EVL_T1H,
  parameter int T_LATCH       = EVL_T_LATCH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 auto,
  input  logic [7:0]           brightness,
  output logic                 mem_en,
  output logic [ADR_WIDTH-1:0] mem_adr,
  input  logic [7:0]           mem_dat,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 led_ctl
);

  localparam int NBYTES = N_LEDS * BYTES_PER_LED;
  localparam int BYW    = $clog2(NBYTES + 1);
  localparam int LCW    = (T_LATCH > 1) ? $clog2(T_LATCH) : 1;
  localparam logic [BYW-1:0]       LAST_BYTE = BYW'(NBYTES - 1);
  localparam logic [LCW-1:0]       LAT_LAST  = LCW'(T_LATCH - 1);
  localparam logic [LCW-1:0]       LAT_PRE   = LCW'(T_LATCH - 2);
  localparam logic [ADR_WIDTH-1:0] ADR_BASE  = ADR_WIDTH'(BASE_ADR);

  evl_state_e           state_q;
  logic [BYW-1:0]       byte_q;
  logic [BYW-1:0]       byte_nxt;
  logic [BYW-1:0]       byte_pf;
  logic [2:0]           bit_q;
  logic [LCW-1:0]       lat_q;
  logic [6:0]           shreg_q;
  logic [7:0]           nxt_q;
  logic [7:0]           dat_scaled;
  logic                 first_q;
  logic                 cap_q;
  logic                 mem_en_q;
  logic [ADR_WIDTH-1:0] adr_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 enter_prime;
  logic                 enc_start;
  logic                 enc_val;
  logic                 enc_last;

`ifdef EVERLOOP_BRIGHTNESS_EN
  logic [7:0] bri_q;
  assign dat_scaled = evl_scale(mem_dat, bri_q);
`else
  logic unused_bri;
  assign unused_bri = ^brightness;
  assign dat_scaled = mem_dat;
`endif

  function automatic logic [ADR_WIDTH-1:0] byte_adr(input logic [BYW-1:0] idx);
    return ADR_BASE + ADR_WIDTH'(idx);
  endfunction

  assign byte_nxt = byte_q + 1'b1;
  assign byte_pf  = byte_q + 2'd2;

  assign enter_prime = ((state_q == ST_IDLE) && (start || auto)) ||
                       ((state_q == ST_LATCH) && (lat_q == LAT_LAST) && auto);

  // Byte 0 starts straight from the RAM read; later bytes come from the prefetch register.
  always_comb begin
    enc_start = 1'b0;
    enc_val   = 1'b0;
    if (state_q == ST_SHIFT) begin
      if (first_q) begin
        enc_start = 1'b1;
        enc_val   = dat_scaled[7];
      end else if (enc_last) begin
        if (bit_q != 3'd0) begin
          enc_start = 1'b1;
          enc_val   = shreg_q[6];
        end else if (byte_q != LAST_BYTE) begin
          enc_start = 1'b1;
          enc_val   = nxt_q[7];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      byte_q   <= '0;
      bit_q    <= '0;
      lat_q    <= '0;
      shreg_q  <= '0;
      nxt_q    <= '0;
      first_q  <= 1'b0;
      cap_q    <= 1'b0;
      mem_en_q <= 1'b0;
      adr_q    <= ADR_BASE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef EVERLOOP_BRIGHTNESS_EN
      bri_q    <= '0;
`endif
    end else begin
      mem_en_q <= 1'b0;
      done_q   <= 1'b0;
      cap_q    <= mem_en_q;
      if (cap_q) nxt_q <= dat_scaled;

      case (state_q)
        ST_IDLE: ;
        ST_PRIME: begin
          state_q <= ST_SHIFT;
          first_q <= 1'b1;
          byte_q  <= '0;
          bit_q   <= 3'd7;
        end
        ST_SHIFT: begin
          if (first_q) begin
            first_q <= 1'b0;
            shreg_q <= dat_scaled[6:0];
            if (LAST_BYTE != '0) begin
              mem_en_q <= 1'b1;
              adr_q    <= byte_adr(BYW'(1));
            end
          end else if (enc_last) begin
            if (bit_q != 3'd0) begin
              bit_q   <= bit_q - 3'd1;
              shreg_q <= {shreg_q[5:0], 1'b0};
            end else if (byte_q == LAST_BYTE) begin
              state_q <= ST_LATCH;
              lat_q   <= '0;
              done_q  <= (T_LATCH == 1);
            end else begin
              byte_q  <= byte_nxt;
              bit_q   <= 3'd7;
              shreg_q <= nxt_q[6:0];
              if (byte_pf <= LAST_BYTE) begin
                mem_en_q <= 1'b1;
                adr_q    <= byte_adr(byte_pf);
              end
            end
          end
        end
        ST_LATCH: begin
          if (lat_q == LAT_LAST) begin
            lat_q   <= '0;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            lat_q  <= lat_q + 1'b1;
            done_q <= (lat_q == LAT_PRE);
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Overrides the LATCH->IDLE exit when auto keeps the refresh running.
      if (enter_prime) begin
        state_q  <= ST_PRIME;
        busy_q   <= 1'b1;
        mem_en_q <= 1'b1;
        adr_q    <= ADR_BASE;
`ifdef EVERLOOP_BRIGHTNESS_EN
        bri_q    <= brightness;
`endif
      end
    end
  end

  everloop_bit_enc #(
    .T_BIT (T_BIT),
    .T0H   (T0H),
    .T1H   (T1H)
  ) u_bit_enc (
    .clk       (clk),
    .rst       (rst),
    .bit_val   (enc_val),
    .bit_start (enc_start),
    .led_ctl   (led_ctl),
    .bit_last  (enc_last)
  );

  assign mem_en     = mem_en_q;
  assign mem_adr    = adr_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_everloop_stream.sv
// Self-checking bench for everloop_stream: frame-position reference model plus line decoder.
module tb_everloop_stream;

  localparam int NL = 2, BPL = 3, AW = 11, BASE = 2046;
  localparam int TB = 10, T0 = 3, T1 = 7, TL = 20;
  localparam int NB   = NL * BPL;
  localparam int BITS = NB * 8;
  localparam int SHN  = 3 + BITS * TB;          // first latch position in a frame
  localparam int FL   = 2 + BITS * TB + TL;     // frame positions 1..FL, FL = frame_done
`ifdef EVERLOOP_BRIGHTNESS_EN
  localparam int EXP_B127 = 8'h7F, EXP_B0 = 8'h00;
`else
  localparam int EXP_B127 = 8'hFF, EXP_B0 = 8'hFF;
`endif

  logic clk = 1'b0, rst = 1'b0, start_s = 1'b0, auto_s = 1'b0;
  logic [7:0] bri_s = 8'd255;
  logic mem_en, busy, frame_done, led_ctl;
  logic [AW-1:0] mem_adr;
  logic [7:0] mem_dat;
  logic [7:0] ram [0:2047];
  int total = 0, bad = 0, cyc = 0;

  everloop_stream #(
    .N_LEDS(NL), .BYTES_PER_LED(BPL), .ADR_WIDTH(AW), .BASE_ADR(BASE),
    .T_BIT(TB), .T0H(T0), .T1H(T1), .T_LATCH(TL)
  ) dut (
    .clk(clk), .rst(rst), .start(start_s), .auto(auto_s), .brightness(bri_s),
    .mem_en(mem_en), .mem_adr(mem_adr), .mem_dat(mem_dat),
    .busy(busy), .frame_done(frame_done), .led_ctl(led_ctl)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) mem_dat <= ram[mem_adr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: cycle %0d got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Reference model: outputs are a pure function of the position within the current frame.
  bit known = 0, after_rst = 0, active = 0;
  int pos = 0;
  int exp_b [NB];

  function automatic void snap();
    for (int i = 0; i < NB; i++) begin
`ifdef EVERLOOP_BRIGHTNESS_EN
      exp_b[i] = (int'(ram[(BASE + i) % 2048]) * (int'(bri_s) + 1)) >> 8;
`else
      exp_b[i] = int'(ram[(BASE + i) % 2048]);
`endif
    end
  endfunction

  always @(negedge clk) begin
    bit e_en, e_led;
    int e_adr, j, ph, by, bi;
    if (known) begin
      e_en = 0; e_led = 0; e_adr = 0;
      if (active) begin
        if (pos == 1) begin
          e_en = 1; e_adr = BASE;
        end else if (pos >= 3 && pos < SHN) begin
          j = (pos - 3) / TB; ph = (pos - 3) % TB;
          by = j / 8; bi = 7 - (j % 8);
          e_led = (ph < (((exp_b[by] >> bi) & 1) != 0 ? T1 : T0));
          if (ph == 0 && (j % 8) == 0 && by < NB - 1) begin
            e_en = 1; e_adr = (BASE + by + 1) % 2048;
          end
        end
      end
      chk("busy", busy, active);
      chk("frame_done", frame_done, active && pos == FL);
      chk("mem_en", mem_en, e_en);
      if (e_en) chk("mem_adr", mem_adr, e_adr);
      chk("led_ctl", led_ctl, e_led);
    end
    if (after_rst) begin
      chk("rst_mem_adr", mem_adr, BASE);
      after_rst = 0;
    end
    if (!rst) begin
      known = 1; active = 0; pos = 0; after_rst = 1;
    end else if (known) begin
      if (!active) begin
        if (start_s || auto_s) begin active = 1; pos = 1; snap(); end
      end else if (pos == FL) begin
        if (auto_s) begin pos = 1; snap(); end
        else begin active = 0; pos = 0; end
      end else begin
        pos++;
      end
    end
  end

  // Line decoder, independent of the model: pulse widths become bits.
  logic led_prev = 1'b0;
  int hi_len = 0;
  int rises[$], dones[$], bits_q[$], hi_lens[$], adrs[$];

  always @(negedge clk) begin
    if (led_ctl === 1'b1) begin
      if (!led_prev) rises.push_back(cyc);
      hi_len++;
    end else if (led_prev) begin
      bits_q.push_back(hi_len == T1 ? 1 : 0);
      hi_lens.push_back(hi_len);
      hi_len = 0;
    end
    led_prev = (led_ctl === 1'b1);
    if (frame_done === 1'b1) dones.push_back(cyc);
    if (mem_en === 1'b1) adrs.push_back(int'(mem_adr));
  end

  function automatic int dec_byte(input int k);
    int v = 0;
    for (int i = 0; i < 8; i++) v = (v << 1) | bits_q[8 * k + i];
    return v;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rises.delete(); dones.delete(); bits_q.delete(); hi_lens.delete(); adrs.delete();
  endtask

  task automatic pulse_start();
    start_s = 1'b1; tick(); start_s = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string nm);
    bit seen = 0;
    for (int k = 0; k < limit && !seen; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL %s: frame_done got none expected within %0d cycles", nm, limit); end
    tick();
  endtask

  task automatic wait_idle(input int limit, input string nm);
    bit seen = 0;
    for (int k = 0; k < limit && !seen; k++) begin
      @(negedge clk);
      if (busy === 1'b0) seen = 1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL %s: busy got 1 expected 0 within %0d cycles", nm, limit); end
    tick();
  endtask

  task automatic check_frame_bytes(input string nm, input int v0, input int v1, input int v2,
                                   input int v3, input int v4, input int v5);
    int lit [6];
    lit = '{v0, v1, v2, v3, v4, v5};
    chk({nm, "_nbits"}, bits_q.size(), BITS);
    if (bits_q.size() >= BITS)
      for (int k = 0; k < NB; k++) chk({nm, "_byte"}, dec_byte(k), lit[k]);
  endtask

  initial begin
    int start_cyc, n;
    int adr_lit [6];
    for (int a = 0; a < 2048; a++) ram[a] = 8'($urandom);

    rst = 1'b0; tick(3); rst = 1'b1; tick(2);
    chk("reset_busy", busy, 0);
    chk("reset_led", led_ctl, 0);

    // Test 1: literal frame, wraps the address space.
    ram[2046] = 8'h80; ram[2047] = 8'h01; ram[0] = 8'hFF;
    ram[1] = 8'h00; ram[2] = 8'hA5; ram[3] = 8'h5A;
    clear_mon();
    start_cyc = cyc;
    pulse_start();
    wait_done(FL + 10, "t1_done");
    check_frame_bytes("t1", 8'h80, 8'h01, 8'hFF, 8'h00, 8'hA5, 8'h5A);
    chk("t1_nrises", rises.size(), 48);
    if (rises.size() == 48 && dones.size() == 1 && hi_lens.size() == 48) begin
      chk("t1_first_hi", hi_lens[0], 7);
      chk("t1_first_period", rises[1] - rises[0], 10);
      chk("t1_start_to_rise", rises[0] - start_cyc, 3);
      chk("t1_frame_span", dones[0] - rises[0] + 1, 500);
      chk("t1_rise_spacing", rises[47] - rises[0], 470);
    end
    adr_lit = '{2046, 2047, 0, 1, 2, 3};
    chk("t1_nadr", adrs.size(), 6);
    if (adrs.size() == 6) for (int k = 0; k < 6; k++) chk("t1_adr_seq", adrs[k], adr_lit[k]);
    chk("t1_busy_after", busy, 0);

    // Test 2: start during shift and during latch is ignored.
    clear_mon();
    pulse_start();
    tick(100);
    pulse_start();
    tick(385);
    pulse_start();
    tick(40);
    chk("t2_ndone", dones.size(), 1);
    chk("t2_nrises", rises.size(), 48);
    chk("t2_busy_after", busy, 0);

    // Test 3: three auto frames, auto dropped mid frame 3.
    clear_mon();
    auto_s = 1'b1;
    wait_done(FL + 10, "t3_done1");
    wait_done(FL + 10, "t3_done2");
    tick(200);
    auto_s = 1'b0;
    wait_done(FL + 10, "t3_done3");
    tick(30);
    chk("t3_ndone", dones.size(), 3);
    chk("t3_nrises", rises.size(), 144);
    if (dones.size() == 3 && rises.size() == 144) begin
      chk("t3_gap1", rises[48] - dones[0], 3);
      chk("t3_gap2", rises[96] - dones[1], 3);
    end
    chk("t3_busy_after", busy, 0);

    // Test 4: reset mid-bit while the line is high, then replay.
    pulse_start();
    tick(150);
    n = 0;
    while (led_ctl !== 1'b1 && n < 20) begin tick(); n++; end
    chk("t4_led_high_before_rst", led_ctl, 1);
    rst = 1'b0; tick(); rst = 1'b1;
    chk("t4_rst_led", led_ctl, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_adr", mem_adr, BASE);
    tick(3);
    for (int i = 0; i < NB; i++) ram[(BASE + i) % 2048] = 8'($urandom);
    clear_mon();
    pulse_start();
    wait_done(FL + 10, "t4_done");
    check_frame_bytes("t4", ram[2046], ram[2047], ram[0], ram[1], ram[2], ram[3]);
    if (adrs.size() > 0) chk("t4_first_adr", adrs[0], BASE);

    // Test 6: brightness scaling, latched per frame.
    for (int i = 0; i < NB; i++) ram[(BASE + i) % 2048] = 8'hFF;
    bri_s = 8'd127;
    clear_mon();
    pulse_start();
    tick(50);
    bri_s = 8'd0;
    wait_done(FL + 10, "t6_done127");
    check_frame_bytes("t6_b127", EXP_B127, EXP_B127, EXP_B127, EXP_B127, EXP_B127, EXP_B127);
    bri_s = 8'd255;
    clear_mon();
    pulse_start();
    wait_done(FL + 10, "t6_done255");
    check_frame_bytes("t6_b255", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    bri_s = 8'd0;
    clear_mon();
    pulse_start();
    wait_done(FL + 10, "t6_done0");
    check_frame_bytes("t6_b0", EXP_B0, EXP_B0, EXP_B0, EXP_B0, EXP_B0, EXP_B0);

    // Randomized traffic; the per-cycle model does the checking.
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < NB; i++) ram[(BASE + i) % 2048] = 8'($urandom);
      bri_s = 8'($urandom);
      auto_s = ($urandom_range(0, 2) == 0);
      pulse_start();
      n = $urandom_range(300, 1200);
      for (int c = 0; c < n; c++) begin
        start_s = ($urandom_range(0, 40) == 0);
        if ($urandom_range(0, 60) == 0) bri_s = 8'($urandom);
        rst = !(it == 3 && c == 250);
        tick();
      end
      start_s = 1'b0; auto_s = 1'b0; rst = 1'b1;
      wait_idle(2 * FL + 20, "rand_idle");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation got no finish expected finish before 1000000 ns");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/everloop_stream.md
# everloop_stream

Parametrised one-wire LED-ring driver for the Everloop chain. It fetches GRB/GRBW bytes from the read port of an 8-bit dual-port everloop RAM and serialises them MSB-first onto a single WS2812-style data line. It supports single-shot or continuous refresh, a start/busy/done handshake, and optional global brightness scaling. It sits between the everloop RAM (port B) and the `led_ctl` pad, replacing the fixed-size everloop engine.

## Interface
- `N_LEDS`, 35: number of LEDs in the chain (≥1)
- `BYTES_PER_LED`, 3: 3 = GRB, 4 = GRBW
- `ADR_WIDTH`, 11: RAM address width
- `BASE_ADR`, 0: RAM address of the first byte of the frame
- `T_BIT`, 63: clocks per bit (1.25 µs at 50 MHz)
- `T0H`, 20: high clocks for a 0 bit; requires 0 < T0H < T1H < T_BIT
- `T1H`, 40: high clocks for a 1 bit
- `T_LATCH`, 2500: low clocks after the last bit (≥ 50 µs)

Ports:
- `clk`  in  1  sole clock; all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `start`  in  1  frame request, sampled only in IDLE
- `auto`  in  1  continuous refresh while high
- `brightness`  in  8  global scale; used only with the macro (see Configuration)
- `mem_en`  out  1  RAM read enable
- `mem_adr`  out  ADR_WIDTH  RAM read address
- `mem_dat`  in  8  RAM read data, valid 1 clk after `mem_en`/`mem_adr`
- `busy`  out  1  high from the first PRIME cycle through the last LATCH cycle
- `frame_done`  out  1  one-clock pulse in the last LATCH cycle
- `led_ctl`  out  1  serial data line

## Operation
- `NBYTES = N_LEDS*BYTES_PER_LED`. Byte i is read from `(BASE_ADR+i) mod 2^ADR_WIDTH`.
- FSM states: IDLE, PRIME, SHIFT, LATCH.
- **IDLE:** `led_ctl`=0, `busy`=0. If `start | auto` → PRIME. Brightness is latched on this transition.
- **PRIME (1 clk):** `mem_en`=1, `mem_adr`=BASE_ADR → SHIFT. The returned byte is loaded into the shift register on entry to SHIFT.
- **SHIFT:** each bit lasts T_BIT clocks. `led_ctl`=1 for the first T1H (bit=1) or T0H (bit=0) clocks of the bit, then 0.
  - Prefetch: in the first clock of bit 7 of byte i (i < NBYTES−1), drive `mem_en`=1 and `mem_adr`=address of byte i+1. Capture into the next-byte register the following clock.
  - After bit 0 of byte i, byte i+1 loads with no gap.
  - After bit 0 of the last byte → LATCH.
- **LATCH:** `led_ctl`=0 for T_LATCH clocks. `frame_done`=1 in the final clock. Next state is PRIME if `auto`=1 at that clock, otherwise IDLE.
- `start` is ignored outside IDLE; there is no queueing.
- Deasserting `auto` mid-frame completes the current frame and its latch, then goes to IDLE.
- Reset, at any time including mid-bit: the next edge forces IDLE. After reset, `led_ctl`=0, `busy`=0, `frame_done`=0, `mem_en`=0, `mem_adr`=BASE_ADR, and all counters are zero.
- Counters:
  - bit-time counter: clog2(T_BIT) bits
  - bit index: 3 bits
  - byte index: clog2(NBYTES+1) bits
  - latch counter: clog2(T_LATCH) bits
- Address arithmetic is ADR_WIDTH-wide and wraps.

## Timing
- Start edge (IDLE sampling `start`=1) → PRIME next cycle → first `led_ctl` rise 2 clocks after the start edge.
- Frame length from first `led_ctl` rise to `frame_done` = `NBYTES*8*T_BIT + T_LATCH` clocks.
- In auto mode, the next frame's first rise occurs 2 clocks after `frame_done`.
- `busy` falls on the clock after `frame_done` unless auto restarts; in that case `busy` stays high.
- RAM latency is fixed at 1 clock. `mem_dat` is ignored except in capture cycles.

## Configuration
- `EVERLOOP_BRIGHTNESS_EN` defined: each byte is scaled before loading into the shift register, as `(byte*(brightness_latched+1))>>8`.
  - The product is 16-bit; the upper 8 bits are used.
  - brightness=255 is the identity; brightness=0 gives 0 for all bytes.
  - Scaling is registered in the capture cycle and adds no latency.
- Macro undefined: bytes are sent unmodified. The `brightness` port remains and is ignored.

## Structure
- Package `everloop_pkg` holds:
  - the FSM state enum
  - default timing constants at 50 MHz (`EVL_T_BIT`, `EVL_T0H`, `EVL_T1H`, `EVL_T_LATCH`)
  - the GRB/GRBW byte-count constants
- Sub-module `everloop_bit_enc`: bit-time counter and high/low pulse generator.
  - Inputs: `bit_val`, `bit_start`.
  - Outputs: `led_ctl`, `bit_last` (last clock of the bit).
  - The top level holds the FSM, byte/bit indices, prefetch and scaling.

## Test plan
Unless stated otherwise, tests use N_LEDS=2, BYTES_PER_LED=3, T_BIT=10, T0H=3, T1H=7, T_LATCH=20, and a RAM model with 1-clock latency.

1. RAM = {0x80,0x01,0xFF,0x00,0xA5,0x5A}, single `start` pulse:
   - the first bit is high for 7 clocks and low for 3
   - decoded stream equals the RAM contents
   - 48 bits, no inter-byte gap
   - `frame_done` occurs exactly 500 clocks after the first rise
2. `start` held for 1 clock while busy, and again during LATCH:
   - ignored
   - exactly one `frame_done` pulse
   - `busy` low on the clock after it
3. `auto`=1 for 3 frames, deasserted mid-frame 3:
   - frame 3 completes with its latch
   - next rise 2 clocks after each `frame_done` until frame 3
   - then IDLE
4. `rst`=0 asserted mid-bit while `led_ctl`=1:
   - next edge forces `led_ctl`=0, `busy`=0, `mem_adr`=BASE_ADR
   - a subsequent `start` replays the frame from byte 0
5. BASE_ADR=2046, ADR_WIDTH=11:
   - `mem_adr` sequence is 2046, 2047, 0, 1, 2, 3
6. With `EVERLOOP_BRIGHTNESS_EN`, brightness=127, byte 0xFF:
   - sent byte is 0x7F
   - brightness=255 sends 0xFF
   - brightness=0 sends 0x00
   - changing brightness mid-frame has no effect until the next frame
